serial_xnor_correlator: RTL and testbench
=========================================

Name: serial_xnor_correlator

Overview:
Sequential consumer of bitwise XNOR equality results. Shifts a serial bit stream into a WIDTH-bit window and compares the window against a loadable reference pattern position by position, using XNOR (1 = bits agree). Counts agreeing positions and flags a detection when the count reaches THRESH. Sits after the XNOR gate stage as the pattern-detect / frame-sync element of the datapath.

Parameters:
WIDTH, 8, window and pattern length in bits (legal range 2..32)
THRESH, 8, minimum agreeing positions for a detection (legal range 1..WIDTH)
CNT_W, 4, width of match_cnt; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
pat_load  input  1  load pat_in as the new reference pattern
pat_in  input  WIDTH  reference pattern, sampled when pat_load=1
bit_valid  input  1  bit_in is valid this cycle; shift it into the window
bit_in  input  1  serial data bit, MSB of pattern arrives first
match_cnt  output  CNT_W  number of window positions equal to the pattern (XNOR popcount)
window_full  output  1  at least WIDTH bits shifted in since the last reset or load
detect  output  1  one-cycle detection pulse
hits  output  8  saturating count of detect pulses

Behaviour:
- One clock. Reset is asynchronous and active-low: rst_n=0 immediately clears pattern, window, fill counter, match_cnt, window_full, detect and hits to 0, independent of clk.
- All outputs are registered. No combinational path from input to output.
- Shift: on an edge with bit_valid=1 and pat_load=0: window <= {window[WIDTH-2:0], bit_in}; fill counter increments and saturates at WIDTH.
- match_cnt = popcount(~(window_next ^ pattern)), registered on the same edge. It reflects the window that includes the bit sampled at that edge, giving 1-cycle latency. Unfilled window positions hold 0 and are compared like any other position.
- window_full = 1 from the edge where the fill counter reaches WIDTH onward.
- detect = 1 for exactly one cycle after a shift edge where the window is full (including the bit just shifted) and match_cnt_next >= THRESH. Otherwise detect = 0, including on cycles with bit_valid=0.
- Overlapping detections are allowed. Every qualifying shift pulses detect, with no re-arm gap.
- hits increments on each detect pulse and saturates at 255. It is cleared only by reset.
- Load: on an edge with pat_load=1: pattern <= pat_in, and window, fill counter, match_cnt, window_full and detect clear to 0. hits is retained.
- Simultaneous pat_load and bit_valid: the load wins and bit_in is discarded.
- bit_valid=0: window, fill counter, match_cnt and window_full hold; detect is 0.
- Reset asserted mid-stream: state clears at once. After rst_n deasserts, WIDTH fresh valid bits are needed before any detect.
- No state machine beyond the fill counter (states FILLING and FULL, with the transition at count=WIDTH, returning to FILLING only on load or reset).

Test Plan:
1. Exact match. WIDTH=8, THRESH=8, load 8'hA5, then shift 1,0,1,0,0,1,0,1 on consecutive cycles. Required: window_full rises after bit 8; detect=1 for one cycle with match_cnt=8; hits=1.
2. Slide-off. Continue test 1 with bit 1. Window becomes 8'h4B. Required: match_cnt=2, detect=0, hits stays 1.
3. Threshold and overlap. THRESH=7, load 8'hA5, shift 1,0,1,0,0,1,0,0 (window 8'hA4). Required: match_cnt=7 and detect=1. Separately, with THRESH=8 and pattern 8'hFF, shift ten 1s. Required: detect pulses on bits 8, 9 and 10, and hits=3.
4. Gaps and collision. Insert bit_valid=0 cycles mid-stream. Required: outputs hold and detect=0 during the gaps, and the final detect timing is unchanged in valid-bit count. Assert pat_load and bit_valid together. Required: bit dropped, match_cnt=0, window_full=0, hits unchanged.
5. Async reset. Pull rst_n low between clock edges after 5 bits. Required: all outputs read 0 before the next edge. After release, 7 matching bits give no detect; the 8th gives a detect. Pattern is 0 after reset.
6. Saturation. Pattern 8'hFF, THRESH=8, shift 270 consecutive 1s. Required: hits reaches 255 and stays there; detect keeps pulsing every cycle after the window fills.

Source files
------------

// File: rtl/serial_xnor_correlator.sv
// serial_xnor_correlator: serial-in sliding window compared against a loadable
// reference pattern by XNOR; counts agreeing positions and pulses detect when
// the full window agrees in at least THRESH positions.
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   pat_load    load pat_in as reference; clears window, fill and outputs
//   pat_in      reference pattern (WIDTH bits)
//   bit_valid   shift bit_in into the window this cycle
//   bit_in      serial data, pattern MSB first
//   match_cnt   registered XNOR popcount of window vs pattern
//   window_full at least WIDTH bits shifted since reset/load
//   detect      one-cycle detection pulse
//   hits        saturating count of detect pulses (cleared by reset only)
module serial_xnor_correlator #(
   parameter int WIDTH  = 8,
   parameter int THRESH = 8,
   parameter int CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pat_load,
   input  logic [WIDTH-1:0] pat_in,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic [CNT_W-1:0] match_cnt,
   output logic             window_full,
   output logic             detect,
   output logic [7:0]       hits
);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] THR  = CNT_W'(THRESH);
   logic [WIDTH-1:0] pattern, window, win_nx, agree;
   logic [CNT_W-1:0] fill, fill_nx, cnt_nx;
   logic             det_nx;
   // Everything is evaluated on the window that already includes bit_in,
   // so the registered outputs reflect the bit sampled at the same edge.
   always_comb begin
      win_nx  = {window[WIDTH-2:0], bit_in};
      fill_nx = (fill == FULL) ? fill : fill + CNT_W'(1);
      agree   = ~(win_nx ^ pattern);
      cnt_nx  = '0;
      for (int i = 0; i < WIDTH; i++) cnt_nx = cnt_nx + CNT_W'(agree[i]);
      det_nx  = (fill_nx == FULL) && (cnt_nx >= THR);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern     <= '0;
         window      <= '0;
         fill        <= '0;
         match_cnt   <= '0;
         window_full <= 1'b0;
         detect      <= 1'b0;
         hits        <= '0;
      end else if (pat_load) begin
         pattern     <= pat_in;
         window      <= '0;
         fill        <= '0;
         match_cnt   <= '0;
         window_full <= 1'b0;
         detect      <= 1'b0;
      end else if (bit_valid) begin
         window      <= win_nx;
         fill        <= fill_nx;
         match_cnt   <= cnt_nx;
         window_full <= fill_nx == FULL;
         detect      <= det_nx;
         if (det_nx && hits != 8'hFF) hits <= hits + 8'd1;
      end else begin
         detect      <= 1'b0;
      end
   end
endmodule

// File: tb/tb_serial_xnor_correlator.sv
// tb_serial_xnor_correlator: scoreboard bench driving two correlators
// (THRESH=8 and THRESH=7) from the same stimulus.
module tb_serial_xnor_correlator;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pat_load = 1'b0;
   logic [7:0] pat_in = '0;
   logic       bit_valid = 1'b0;
   logic       bit_in = 1'b0;
   logic [3:0] cnt8, cnt7;
   logic       full8, full7, det8, det7;
   logic [7:0] hits8, hits7;
   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic [3:0] cnt;
      logic       full;
      logic       d8;
      logic       d7;
      logic [7:0] h8;
      logic [7:0] h7;
   } exp_t;
   exp_t q[$];

   logic [7:0] m_pat, m_win;
   int         m_fill;
   exp_t       m;

   always #5 clk = ~clk;

   serial_xnor_correlator #(.WIDTH(8), .THRESH(8), .CNT_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .pat_load(pat_load), .pat_in(pat_in),
      .bit_valid(bit_valid), .bit_in(bit_in), .match_cnt(cnt8),
      .window_full(full8), .detect(det8), .hits(hits8));

   serial_xnor_correlator #(.WIDTH(8), .THRESH(7), .CNT_W(4)) dut7 (
      .clk(clk), .rst_n(rst_n), .pat_load(pat_load), .pat_in(pat_in),
      .bit_valid(bit_valid), .bit_in(bit_in), .match_cnt(cnt7),
      .window_full(full7), .detect(det7), .hits(hits7));

   task automatic model_reset();
      m_pat = '0; m_win = '0; m_fill = 0; m = '0;
   endtask

   // Drive one cycle, push model prediction, then pop and compare after the edge.
   task automatic cycle(input logic pl, input logic [7:0] pin, input logic bv, input logic b);
      exp_t e;
      @(negedge clk);
      pat_load = pl; pat_in = pin; bit_valid = bv; bit_in = b;
      if (pl) begin
         m_pat = pin; m_win = '0; m_fill = 0;
         m.cnt = 0; m.full = 0; m.d8 = 0; m.d7 = 0;
      end else if (bv) begin
         m_win = {m_win[6:0], b};
         if (m_fill < 8) m_fill++;
         m.cnt  = 4'($countones(~(m_win ^ m_pat)));
         m.full = (m_fill == 8);
         m.d8   = m.full && m.cnt >= 8;
         m.d7   = m.full && m.cnt >= 7;
         if (m.d8 && m.h8 != 8'hFF) m.h8++;
         if (m.d7 && m.h7 != 8'hFF) m.h7++;
      end else begin
         m.d8 = 0; m.d7 = 0;
      end
      q.push_back(m);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         bad++; total++;
         $display("FAIL scoreboard_empty");
      end else begin
         e = q.pop_front();
         total += 8;
         if (cnt8 !== e.cnt) begin bad++; $display("FAIL match_cnt8 got=%0d exp=%0d t=%0t", cnt8, e.cnt, $time); end
         if (cnt7 !== e.cnt) begin bad++; $display("FAIL match_cnt7 got=%0d exp=%0d t=%0t", cnt7, e.cnt, $time); end
         if (full8 !== e.full) begin bad++; $display("FAIL window_full8 got=%b exp=%b t=%0t", full8, e.full, $time); end
         if (full7 !== e.full) begin bad++; $display("FAIL window_full7 got=%b exp=%b t=%0t", full7, e.full, $time); end
         if (det8 !== e.d8) begin bad++; $display("FAIL detect8 got=%b exp=%b t=%0t", det8, e.d8, $time); end
         if (det7 !== e.d7) begin bad++; $display("FAIL detect7 got=%b exp=%b t=%0t", det7, e.d7, $time); end
         if (hits8 !== e.h8) begin bad++; $display("FAIL hits8 got=%0d exp=%0d t=%0t", hits8, e.h8, $time); end
         if (hits7 !== e.h7) begin bad++; $display("FAIL hits7 got=%0d exp=%0d t=%0t", hits7, e.h7, $time); end
      end
   endtask

   task automatic shift_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) cycle(1'b0, 8'h00, 1'b1, v[i]);
   endtask

   task automatic check_zero(input string name);
      total++;
      if ({cnt8, full8, det8, hits8, cnt7, full7, det7, hits7} !== '0) begin
         bad++;
         $display("FAIL %s outputs got cnt=%0d full=%b det=%b hits=%0d exp all 0", name, cnt8, full8, det8, hits8);
      end
   endtask

   task automatic test_reset();
      model_reset();
      #2;
      check_zero("reset_initial");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_exact_match();
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      shift_byte(8'hA5);
      total++;
      if (hits8 !== 8'd1 || det8 !== 1'b1 || cnt8 !== 4'd8) begin
         bad++; $display("FAIL exact_match hits=%0d det=%b cnt=%0d exp 1/1/8", hits8, det8, cnt8);
      end
   endtask

   task automatic test_slide_off();
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      total++;
      if (cnt8 !== 4'd2 || det8 !== 1'b0 || hits8 !== 8'd1) begin
         bad++; $display("FAIL slide_off cnt=%0d det=%b hits=%0d exp 2/0/1", cnt8, det8, hits8);
      end
   endtask

   task automatic test_threshold_overlap();
      logic [7:0] h0;
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      shift_byte(8'hA4);
      total++;
      if (cnt7 !== 4'd7 || det7 !== 1'b1 || det8 !== 1'b0) begin
         bad++; $display("FAIL thresh7 cnt=%0d det7=%b det8=%b exp 7/1/0", cnt7, det7, det8);
      end
      cycle(1'b1, 8'hFF, 1'b0, 1'b0);
      h0 = hits8;
      for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
      total++;
      if (hits8 !== h0 + 8'd3) begin
         bad++; $display("FAIL overlap_hits got=%0d exp=%0d", hits8, h0 + 8'd3);
      end
   endtask

   task automatic test_gaps_collision();
      logic [7:0] h0;
      cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      for (int i = 7; i >= 4; i--) cycle(1'b0, 8'h00, 1'b1, 1'(8'h5A >> i));
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 3; i >= 0; i--) cycle(1'b0, 8'h00, 1'b1, 1'(8'h5A >> i));
      total++;
      if (det8 !== 1'b1) begin bad++; $display("FAIL gap_detect got=%b exp=1", det8); end
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      h0 = hits8;
      cycle(1'b1, 8'h3C, 1'b1, 1'b1);
      total++;
      if (cnt8 !== 4'd0 || full8 !== 1'b0 || hits8 !== h0) begin
         bad++; $display("FAIL collision cnt=%0d full=%b hits=%0d exp 0/0/%0d", cnt8, full8, hits8, h0);
      end
   endtask

   task automatic test_async_reset();
      cycle(1'b1, 8'hC3, 1'b0, 1'b0);
      for (int i = 7; i >= 3; i--) cycle(1'b0, 8'h00, 1'b1, 1'(8'hC3 >> i));
      #2;
      pat_load = 1'b0; bit_valid = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_zero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (det8 !== 1'b0) begin bad++; $display("FAIL reset_7bits det=%b exp=0", det8); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (det8 !== 1'b1 || hits8 !== 8'd1) begin
         bad++; $display("FAIL reset_8th det=%b hits=%0d exp 1/1", det8, hits8);
      end
   endtask

   task automatic test_saturation();
      cycle(1'b1, 8'hFF, 1'b0, 1'b0);
      for (int i = 0; i < 270; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
      total++;
      if (hits8 !== 8'd255 || det8 !== 1'b1 || hits7 !== 8'd255) begin
         bad++; $display("FAIL saturation hits8=%0d hits7=%0d det=%b exp 255/255/1", hits8, hits7, det8);
      end
   endtask

   initial begin
      test_reset();
      test_exact_match();
      test_slide_off();
      test_threshold_overlap();
      test_gaps_collision();
      test_async_reset();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
